// File: rtl/if_alu_seq.sv
// if_alu_seq
// Sequential compare-and-update unit. An (A, B) operand pair is accepted over
// a valid/ready handshake. The pair then drives a two-stage update of the
// WA-bit working register temp, which starts at B[WA-1:0]:
//   A > B  : temp + A, then temp - A
//   A < B  : zext(temp) - B (truncated), then temp + A
//   A == B : temp * B[WA-1:0], then temp / A, then temp + 1
// The result is returned zero-extended on XOUT.
// Multiply is an iterative shift-add and divide is a restoring divider.
// Each of them takes exactly WA clock edges.
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   IN_VALID   operand pair valid
//   IN_READY   block can accept a pair (IDLE only)
//   A [WA]     operand A, unsigned
//   B [WB]     operand B, unsigned
//   OUT_VALID  XOUT holds a result (DONE state)
//   OUT_READY  consumer accepts the result
//   XOUT [WB]  result, temp zero-extended
//   BUSY       high in any state other than IDLE
//
// Optional feature, enabled by the macro IF_ALU_SEQ_SAT_EN:
//   Additions, the multiply and the final increment saturate at 2^WA-1.
//   Subtractions clamp at 0.
//   Without the macro, all arithmetic wraps modulo 2^WA.
module if_alu_seq #(
  parameter int WA = 8,
  parameter int WB = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [WA-1:0] A,
  input  logic [WB-1:0] B,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [WB-1:0] XOUT,
  output logic          BUSY
);

  localparam int CW = (WA > 1) ? $clog2(WA) : 1;
`ifdef IF_ALU_SEQ_SAT_EN
  // The full product is kept so that overflow past WA bits can be detected.
  localparam int PW = 2 * WA;
`else
  localparam int PW = WA;
`endif

  typedef enum logic [2:0] {IDLE, S1, MUL, S2, DIV, FIN, DONE} state_t;

  state_t        state_reg, state_next;
  logic [WA-1:0] a_reg;
  logic [WB-1:0] b_reg;
  logic [WA-1:0] temp_reg;
  logic [WA-1:0] rem_reg;
  logic [PW-1:0] acc_reg, mcand_reg;
  logic [WA-1:0] mplier_reg;
  logic [CW-1:0] cnt_reg;

  logic          gt, lt, eq, last_step;
  logic [WA-1:0] add_res, sub_a_res, sub_b_res, inc_res, mul_res;
  logic [PW-1:0] acc_next;
  logic [WA:0]   div_shift;
  logic          div_ge;
  logic [WA-1:0] div_rem_next, div_quo_next;

  assign gt        = WB'(a_reg) > b_reg;
  assign lt        = WB'(a_reg) < b_reg;
  assign eq        = ~gt & ~lt;
  assign last_step = (cnt_reg == CW'(WA - 1));

  // Multiplier step.
  assign acc_next = mplier_reg[0] ? acc_reg + mcand_reg : acc_reg;

  // Restoring divider step.
  // The dividend/quotient shifts through temp_reg.
  // When the subtraction happens, the true remainder is below A, so a
  // WA-bit subtract is exact.
  // A == 0 makes every step subtract, so the quotient ends up all-ones.
  assign div_shift    = {rem_reg, temp_reg[WA-1]};
  assign div_ge       = div_shift >= {1'b0, a_reg};
  assign div_rem_next = div_ge ? div_shift[WA-1:0] - a_reg : div_shift[WA-1:0];
  assign div_quo_next = {temp_reg[WA-2:0], div_ge};

  always_comb begin
    add_res   = '0;
    sub_a_res = '0;
    sub_b_res = '0;
    inc_res   = '0;
    mul_res   = '0;
`ifdef IF_ALU_SEQ_SAT_EN
    add_res   = ({1'b0, temp_reg} + {1'b0, a_reg} > {1'b0, {WA{1'b1}}}) ?
                {WA{1'b1}} : temp_reg + a_reg;
    sub_a_res = (temp_reg < a_reg) ? '0 : temp_reg - a_reg;
    // If zext(temp) >= B, then B fits in WA bits, so the low-slice
    // subtract is exact.
    sub_b_res = (WB'(temp_reg) < b_reg) ? '0 : temp_reg - b_reg[WA-1:0];
    inc_res   = (&temp_reg) ? temp_reg : temp_reg + 1'b1;
    mul_res   = (|acc_next[PW-1:WA]) ? {WA{1'b1}} : acc_next[WA-1:0];
`else
    add_res   = temp_reg + a_reg;
    sub_a_res = temp_reg - a_reg;
    // Truncating (zext(temp) - B) to WA bits equals temp - B[WA-1:0] mod 2^WA.
    sub_b_res = temp_reg - b_reg[WA-1:0];
    inc_res   = temp_reg + 1'b1;
    mul_res   = acc_next[WA-1:0];
`endif
  end

  // State register.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (IN_VALID) state_next = S1;
      S1:      state_next = eq ? MUL : S2;
      MUL:     if (last_step) state_next = DIV;
      S2:      state_next = DONE;
      DIV:     if (last_step) state_next = FIN;
      FIN:     state_next = DONE;
      DONE:    if (OUT_READY) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      a_reg      <= '0;
      b_reg      <= '0;
      temp_reg   <= '0;
      rem_reg    <= '0;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: if (IN_VALID) begin
          a_reg    <= A;
          b_reg    <= B;
          temp_reg <= B[WA-1:0];
        end
        S1: begin
          if (gt)      temp_reg <= add_res;
          else if (lt) temp_reg <= sub_b_res;
          else begin
            acc_reg    <= '0;
            mcand_reg  <= PW'(temp_reg);
            mplier_reg <= b_reg[WA-1:0];
            cnt_reg    <= '0;
          end
        end
        MUL: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_reg << 1;
          mplier_reg <= mplier_reg >> 1;
          cnt_reg    <= last_step ? '0 : cnt_reg + 1'b1;
          if (last_step) begin
            temp_reg <= mul_res;
            rem_reg  <= '0;
          end
        end
        S2:  temp_reg <= gt ? sub_a_res : add_res;
        DIV: begin
          rem_reg  <= div_rem_next;
          temp_reg <= div_quo_next;
          cnt_reg  <= last_step ? '0 : cnt_reg + 1'b1;
        end
        FIN:     temp_reg <= inc_res;
        default: ;
      endcase
    end
  end

  assign IN_READY  = (state_reg == IDLE);
  assign BUSY      = (state_reg != IDLE);
  assign OUT_VALID = (state_reg == DONE);
  assign XOUT      = OUT_VALID ? WB'(temp_reg) : '0;

endmodule

// File: tb/tb_if_alu_seq.sv
module tb_if_alu_seq;
  localparam int WA = 8;
  localparam int WB = 16;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          IN_VALID = 1'b0;
  logic          IN_READY;
  logic [WA-1:0] A = '0;
  logic [WB-1:0] B = '0;
  logic          OUT_VALID;
  logic          OUT_READY = 1'b0;
  logic [WB-1:0] XOUT;
  logic          BUSY;

  int checks = 0;
  int failures = 0;

`ifdef IF_ALU_SEQ_SAT_EN
  localparam logic [WB-1:0] EXP_ZERO = 16'h00FF;
  localparam logic [WB-1:0] EXP_WRAP = 16'h000F;
`else
  localparam logic [WB-1:0] EXP_ZERO = 16'h0000;
  localparam logic [WB-1:0] EXP_WRAP = 16'h0020;
`endif

  always #5 CLK = ~CLK;

  if_alu_seq #(.WA(WA), .WB(WB)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .A(A), .B(B), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .XOUT(XOUT), .BUSY(BUSY)
  );

  // Drives one pair and waits (bounded) for OUT_VALID. Returns the number of
  // rising edges from accept to OUT_VALID, whether BUSY held in between, and
  // IN_READY as seen at the offer.
  task automatic run_op(input logic [WA-1:0] a, input logic [WB-1:0] b,
                        output int lat, output bit busy_ok, output bit rdy_ok);
    @(negedge CLK);
    rdy_ok = IN_READY;
    A = a; B = b; IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!OUT_VALID && lat < 100) begin
      if (!BUSY) busy_ok = 1'b0;
      @(posedge CLK);
      lat++;
      @(negedge CLK);
    end
    $display("op A=%h B=%h XOUT=%h OUT_VALID=%b latency=%0d", a, b, XOUT, OUT_VALID, lat);
  endtask

  task automatic consume;
    OUT_READY = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge CLK);
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL rst_in_ready: got %b expected 1", IN_READY); end
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL rst_out_valid: got %b expected 0", OUT_VALID); end
    checks++; if (XOUT !== 16'h0000) begin failures++; $display("FAIL rst_xout: got %h expected 0000", XOUT); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b expected 0", BUSY); end
    RST_N = 1'b1;
    repeat (3) @(negedge CLK);
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL idle_no_valid_busy: got %b expected 0", BUSY); end
    $display("reset released, idle with IN_VALID low");
  endtask

  task automatic test_gt;
    int lat; bit busy_ok, rdy_ok;
    run_op(8'h30, 16'h0010, lat, busy_ok, rdy_ok);
    checks++; if (rdy_ok !== 1'b1) begin failures++; $display("FAIL gt_in_ready: got %b expected 1", rdy_ok); end
    checks++; if (lat != 2) begin failures++; $display("FAIL gt_latency: got %0d expected 2", lat); end
    checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL gt_busy: got %b expected 1", busy_ok); end
    checks++; if (XOUT !== 16'h0010) begin failures++; $display("FAIL gt_xout: got %h expected 0010", XOUT); end
    consume();
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL gt_after_out_valid: got %b expected 0", OUT_VALID); end
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL gt_after_in_ready: got %b expected 1", IN_READY); end
  endtask

  task automatic test_lt;
    int lat; bit busy_ok, rdy_ok;
    run_op(8'h05, 16'h0103, lat, busy_ok, rdy_ok);
    checks++; if (lat != 2) begin failures++; $display("FAIL lt_latency: got %0d expected 2", lat); end
    checks++; if (XOUT !== 16'h0005) begin failures++; $display("FAIL lt_xout: got %h expected 0005", XOUT); end
    consume();
  endtask

  task automatic test_eq;
    int lat; bit busy_ok, rdy_ok;
    run_op(8'h07, 16'h0007, lat, busy_ok, rdy_ok);
    checks++; if (lat != 18) begin failures++; $display("FAIL eq_latency: got %0d expected 18", lat); end
    checks++; if (busy_ok !== 1'b1) begin failures++; $display("FAIL eq_busy: got %b expected 1", busy_ok); end
    checks++; if (XOUT !== 16'h0008) begin failures++; $display("FAIL eq_xout: got %h expected 0008", XOUT); end
    consume();
  endtask

  task automatic test_zero;
    int lat; bit busy_ok, rdy_ok;
    run_op(8'h00, 16'h0000, lat, busy_ok, rdy_ok);
    checks++; if (lat != 18) begin failures++; $display("FAIL zero_latency: got %0d expected 18", lat); end
    checks++; if (XOUT !== EXP_ZERO) begin failures++; $display("FAIL zero_xout: got %h expected %h", XOUT, EXP_ZERO); end
    consume();
  endtask

  task automatic test_wrap;
    int lat; bit busy_ok, rdy_ok;
    run_op(8'hF0, 16'h0020, lat, busy_ok, rdy_ok);
    checks++; if (XOUT !== EXP_WRAP) begin failures++; $display("FAIL wrap_xout: got %h expected %h", XOUT, EXP_WRAP); end
    consume();
  endtask

  task automatic test_backpressure;
    int lat; bit busy_ok, rdy_ok;
    run_op(8'h05, 16'h0103, lat, busy_ok, rdy_ok);
    // An offered pair while DONE must be ignored.
    A = 8'h30; B = 16'h0010; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      checks++; if (OUT_VALID !== 1'b1) begin failures++; $display("FAIL bp_out_valid[%0d]: got %b expected 1", i, OUT_VALID); end
      checks++; if (XOUT !== 16'h0005) begin failures++; $display("FAIL bp_xout[%0d]: got %h expected 0005", i, XOUT); end
      checks++; if (IN_READY !== 1'b0) begin failures++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", i, IN_READY); end
    end
    IN_VALID = 1'b0;
    $display("backpressure held 5 cycles XOUT=%h", XOUT);
    consume();
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL bp_release_busy: got %b expected 0", BUSY); end
  endtask

  task automatic test_reset_mid_div;
    int lat; bit busy_ok, rdy_ok;
    @(negedge CLK);
    A = 8'h07; B = 16'h0007; IN_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    IN_VALID = 1'b0;
    // Go through S1 (1 edge), MUL (8 edges) and 3 edges into DIV.
    repeat (12) @(posedge CLK);
    @(negedge CLK);
    checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL div_busy: got %b expected 1", BUSY); end
    RST_N = 1'b0;
    #1;
    checks++; if (OUT_VALID !== 1'b0) begin failures++; $display("FAIL midrst_out_valid: got %b expected 0", OUT_VALID); end
    checks++; if (XOUT !== 16'h0000) begin failures++; $display("FAIL midrst_xout: got %h expected 0000", XOUT); end
    checks++; if (IN_READY !== 1'b1) begin failures++; $display("FAIL midrst_in_ready: got %b expected 1", IN_READY); end
    checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL midrst_busy: got %b expected 0", BUSY); end
    $display("reset pulsed during DIV");
    @(negedge CLK);
    RST_N = 1'b1;
    run_op(8'h30, 16'h0010, lat, busy_ok, rdy_ok);
    checks++; if (lat != 2) begin failures++; $display("FAIL postrst_latency: got %0d expected 2", lat); end
    checks++; if (XOUT !== 16'h0010) begin failures++; $display("FAIL postrst_xout: got %h expected 0010", XOUT); end
    consume();
    run_op(8'h07, 16'h0007, lat, busy_ok, rdy_ok);
    checks++; if (XOUT !== 16'h0008) begin failures++; $display("FAIL postrst_eq_xout: got %h expected 0008", XOUT); end
    consume();
  endtask

  initial begin
    test_reset();
    test_gt();
    test_lt();
    test_eq();
    test_zero();
    test_wrap();
    test_backpressure();
    test_reset_mid_div();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
